// File: rtl/id_ex_pipeline_register_if.sv
// Decode-to-execute bundle: decoded control, operands, handshake.
// Shared by the control decoder side (master) and the ID/EX register (slave).
interface id_ex_pipeline_register_if #(
   parameter int XLEN = 32
);
   logic            id_write;
   logic            id_store;
   logic            id_load;
   logic            id_branch;
   logic [1:0]      id_alu_operand_a_selector;
   logic            id_alu_operand_b_selector;
   logic [1:0]      id_immediate_selector;
   logic [1:0]      id_next_pc_selector;
   logic [2:0]      id_alu_operations_selector;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [XLEN-1:0] id_immediate;
   logic [4:0]      id_rd;
   logic [4:0]      id_rs1;
   logic [4:0]      id_rs2;
   logic [2:0]      id_funct3;
   logic            id_rs1_used;
   logic            id_rs2_used;
   logic            id_valid;
   logic            ex_hold;
   logic            flush;

   logic            ex_write;
   logic            ex_store;
   logic            ex_load;
   logic            ex_branch;
   logic [1:0]      ex_alu_operand_a_selector;
   logic            ex_alu_operand_b_selector;
   logic [1:0]      ex_immediate_selector;
   logic [1:0]      ex_next_pc_selector;
   logic [2:0]      ex_alu_operations_selector;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_rs1_data;
   logic [XLEN-1:0] ex_rs2_data;
   logic [XLEN-1:0] ex_immediate;
   logic [4:0]      ex_rd;
   logic [4:0]      ex_rs1;
   logic [4:0]      ex_rs2;
   logic [2:0]      ex_funct3;
   logic            ex_valid;
   logic            id_stall;
   logic [15:0]     bubble_count;

   modport master (
      output id_write, id_store, id_load, id_branch,
      output id_alu_operand_a_selector, id_alu_operand_b_selector,
      output id_immediate_selector, id_next_pc_selector,
      output id_alu_operations_selector,
      output id_pc, id_rs1_data, id_rs2_data, id_immediate,
      output id_rd, id_rs1, id_rs2, id_funct3,
      output id_rs1_used, id_rs2_used, id_valid,
      output ex_hold, flush,
      input  ex_write, ex_store, ex_load, ex_branch,
      input  ex_alu_operand_a_selector, ex_alu_operand_b_selector,
      input  ex_immediate_selector, ex_next_pc_selector,
      input  ex_alu_operations_selector,
      input  ex_pc, ex_rs1_data, ex_rs2_data, ex_immediate,
      input  ex_rd, ex_rs1, ex_rs2, ex_funct3,
      input  ex_valid, id_stall, bubble_count
   );

   modport slave (
      input  id_write, id_store, id_load, id_branch,
      input  id_alu_operand_a_selector, id_alu_operand_b_selector,
      input  id_immediate_selector, id_next_pc_selector,
      input  id_alu_operations_selector,
      input  id_pc, id_rs1_data, id_rs2_data, id_immediate,
      input  id_rd, id_rs1, id_rs2, id_funct3,
      input  id_rs1_used, id_rs2_used, id_valid,
      input  ex_hold, flush,
      output ex_write, ex_store, ex_load, ex_branch,
      output ex_alu_operand_a_selector, ex_alu_operand_b_selector,
      output ex_immediate_selector, ex_next_pc_selector,
      output ex_alu_operations_selector,
      output ex_pc, ex_rs1_data, ex_rs2_data, ex_immediate,
      output ex_rd, ex_rs1, ex_rs2, ex_funct3,
      output ex_valid, id_stall, bubble_count
   );
endinterface

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with flush, hold and load-use bubble injection.
// Define HAZARD_DETECT_EN to enable load-use detection and bubble_count.
module id_ex_pipeline_register #(
   parameter int XLEN = 32
) (
   input logic                  clk,
   input logic                  rst,
   id_ex_pipeline_register_if.slave bus
);
   typedef struct packed {
      logic       write;
      logic       store;
      logic       load;
      logic       branch;
      logic [1:0] asel;
      logic       bsel;
      logic [1:0] isel;
      logic [1:0] npc;
      logic [2:0] alu;
   } ctrl_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
   } data_t;

   ctrl_t r_ctrl;
   data_t r_data;
   logic  r_valid;
   ctrl_t w_ctrl_in;
   data_t w_data_in;
   logic  w_hazard;
   logic  w_bubble;

   assign w_ctrl_in = '{
      write:  bus.id_write,
      store:  bus.id_store,
      load:   bus.id_load,
      branch: bus.id_branch,
      asel:   bus.id_alu_operand_a_selector,
      bsel:   bus.id_alu_operand_b_selector,
      isel:   bus.id_immediate_selector,
      npc:    bus.id_next_pc_selector,
      alu:    bus.id_alu_operations_selector
   };

   assign w_data_in = '{
      pc:       bus.id_pc,
      rs1_data: bus.id_rs1_data,
      rs2_data: bus.id_rs2_data,
      imm:      bus.id_immediate,
      rd:       bus.id_rd,
      rs1:      bus.id_rs1,
      rs2:      bus.id_rs2,
      funct3:   bus.id_funct3
   };

`ifdef HAZARD_DETECT_EN
   logic [15:0] r_bubble_count;

   // Load in EX whose nonzero rd is read by the real instruction in ID.
   assign w_hazard = r_valid & r_ctrl.load & (r_data.rd != 5'd0)
                   & bus.id_valid
                   & ((bus.id_rs1_used & (bus.id_rs1 == r_data.rd))
                    | (bus.id_rs2_used & (bus.id_rs2 == r_data.rd)));

   // Count injected bubbles, saturating so the counter never wraps.
   always_ff @(posedge clk) begin
      if (rst)
         r_bubble_count <= '0;
      else if (!bus.flush && w_bubble && r_bubble_count != 16'hFFFF)
         r_bubble_count <= r_bubble_count + 16'd1;
   end

   assign bus.bubble_count = r_bubble_count;
`else
   logic w_unused_used_bits;

   assign w_unused_used_bits = bus.id_rs1_used ^ bus.id_rs2_used;
   assign w_hazard           = 1'b0;
   assign bus.bubble_count   = '0;
`endif

   // A held EX stage absorbs the hazard: the load stays put, decode waits.
   assign w_bubble     = w_hazard & ~bus.ex_hold;
   assign bus.id_stall = w_hazard | bus.ex_hold;

   // Priority: reset, flush, bubble, hold, capture. Bubbles keep data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctrl  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (bus.flush || w_bubble) begin
         r_ctrl  <= '0;
         r_valid <= 1'b0;
      end else if (!bus.ex_hold) begin
         r_ctrl  <= w_ctrl_in;
         r_data  <= w_data_in;
         r_valid <= bus.id_valid;
      end
   end

   assign bus.ex_write                   = r_ctrl.write;
   assign bus.ex_store                   = r_ctrl.store;
   assign bus.ex_load                    = r_ctrl.load;
   assign bus.ex_branch                  = r_ctrl.branch;
   assign bus.ex_alu_operand_a_selector  = r_ctrl.asel;
   assign bus.ex_alu_operand_b_selector  = r_ctrl.bsel;
   assign bus.ex_immediate_selector      = r_ctrl.isel;
   assign bus.ex_next_pc_selector        = r_ctrl.npc;
   assign bus.ex_alu_operations_selector = r_ctrl.alu;
   assign bus.ex_pc                      = r_data.pc;
   assign bus.ex_rs1_data                = r_data.rs1_data;
   assign bus.ex_rs2_data                = r_data.rs2_data;
   assign bus.ex_immediate               = r_data.imm;
   assign bus.ex_rd                      = r_data.rd;
   assign bus.ex_rs1                     = r_data.rs1;
   assign bus.ex_rs2                     = r_data.rs2;
   assign bus.ex_funct3                  = r_data.funct3;
   assign bus.ex_valid                   = r_valid;
endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed bench for id_ex_pipeline_register.
// Expectations follow HAZARD_DETECT_EN as defined for the build.
module tb_id_ex_pipeline_register;
`ifdef HAZARD_DETECT_EN
   localparam bit HZ = 1'b1;
`else
   localparam bit HZ = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   id_ex_pipeline_register_if #(.XLEN(32)) bus ();

   id_ex_pipeline_register #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive(input bit v, input bit ld, input logic [4:0] rd,
                        input logic [4:0] rs1, input bit u1,
                        input logic [4:0] rs2, input bit u2,
                        input logic [31:0] pc);
      bus.id_valid                   = v;
      bus.id_write                   = 1'b1;
      bus.id_store                   = 1'b0;
      bus.id_load                    = ld;
      bus.id_branch                  = 1'b0;
      bus.id_alu_operand_a_selector  = 2'd1;
      bus.id_alu_operand_b_selector  = ld;
      bus.id_immediate_selector      = 2'd2;
      bus.id_next_pc_selector        = 2'd1;
      bus.id_alu_operations_selector = ld ? 3'd0 : 3'd3;
      bus.id_pc                      = pc;
      bus.id_rs1_data                = pc + 32'd1;
      bus.id_rs2_data                = pc + 32'd2;
      bus.id_immediate               = pc + 32'd3;
      bus.id_rd                      = rd;
      bus.id_rs1                     = rs1;
      bus.id_rs2                     = rs2;
      bus.id_funct3                  = ld ? 3'b010 : 3'b000;
      bus.id_rs1_used                = u1;
      bus.id_rs2_used                = u2;
   endtask

   initial begin
      bus.ex_hold = 1'b0;
      bus.flush   = 1'b0;
      drive(1, 0, 5'd5, 5'd1, 1, 5'd2, 1, 32'h100);

      // reset held for two edges with an ADD presented
      tick();
      tick();
      check("rst_write", bus.ex_write, 0);
      check("rst_rd", bus.ex_rd, 0);
      check("rst_valid", bus.ex_valid, 0);
      check("rst_pc", bus.ex_pc, 0);
      check("rst_bcnt", bus.bubble_count, 0);
      check("rst_stall", bus.id_stall, 0);

      // capture
      rst = 1'b0;
      tick();
      check("cap_write", bus.ex_write, 1);
      check("cap_rd", bus.ex_rd, 5);
      check("cap_valid", bus.ex_valid, 1);
      check("cap_pc", bus.ex_pc, 32'h100);
      check("cap_rs2d", bus.ex_rs2_data, 32'h102);
      check("cap_alu", bus.ex_alu_operations_selector, 3);

      // load-use: LW x6 then ADD x7, x6, x1
      drive(1, 1, 5'd6, 5'd2, 1, 5'd0, 0, 32'h104);
      tick();
      check("lu_ld", bus.ex_load, 1);
      drive(1, 0, 5'd7, 5'd6, 1, 5'd1, 1, 32'h108);
      settle();
      check("lu_stall", bus.id_stall, HZ);
      tick();
      check("lu_bub_valid", bus.ex_valid, !HZ);
      check("lu_bub_write", bus.ex_write, !HZ);
      check("lu_stall2", bus.id_stall, 0);
      check("lu_bcnt", bus.bubble_count, HZ);
      tick();
      check("lu_add_rd", bus.ex_rd, 7);
      check("lu_add_valid", bus.ex_valid, 1);
      check("lu_add_pc", bus.ex_pc, 32'h108);

      // LW x0 followed by a reader of x0
      drive(1, 1, 5'd0, 5'd2, 1, 5'd0, 0, 32'h10C);
      tick();
      drive(1, 0, 5'd8, 5'd0, 1, 5'd0, 1, 32'h110);
      settle();
      check("x0_stall", bus.id_stall, 0);
      tick();
      check("x0_valid", bus.ex_valid, 1);
      check("x0_rd", bus.ex_rd, 8);
      check("x0_bcnt", bus.bubble_count, HZ);

      // LW x6 followed by LUI x6 (rs fields match, but unused)
      drive(1, 1, 5'd6, 5'd2, 1, 5'd0, 0, 32'h114);
      tick();
      drive(1, 0, 5'd6, 5'd6, 0, 5'd6, 0, 32'h118);
      settle();
      check("lui_stall", bus.id_stall, 0);
      tick();
      check("lui_valid", bus.ex_valid, 1);
      check("lui_pc", bus.ex_pc, 32'h118);
      check("lui_bcnt", bus.bubble_count, HZ);

      // flush beats hazard and hold; data fields keep the load's values
      drive(1, 1, 5'd6, 5'd2, 1, 5'd0, 0, 32'h11C);
      tick();
      drive(1, 0, 5'd9, 5'd6, 1, 5'd0, 0, 32'h120);
      bus.ex_hold = 1'b1;
      bus.flush   = 1'b1;
      settle();
      check("fl_stall", bus.id_stall, 1);
      tick();
      check("fl_valid", bus.ex_valid, 0);
      check("fl_write", bus.ex_write, 0);
      check("fl_load", bus.ex_load, 0);
      check("fl_npc", bus.ex_next_pc_selector, 0);
      check("fl_alu_b", bus.ex_alu_operand_b_selector, 0);
      check("fl_rd_kept", bus.ex_rd, 6);
      check("fl_pc_kept", bus.ex_pc, 32'h11C);
      check("fl_bcnt", bus.bubble_count, HZ);
      bus.ex_hold = 1'b0;
      bus.flush   = 1'b0;

      // hold three cycles while decode changes underneath
      drive(1, 0, 5'd9, 5'd1, 1, 5'd2, 1, 32'h200);
      tick();
      bus.ex_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 5'(10 + i), 5'd3, 1, 5'd4, 0, 32'h204 + 32'(4 * i));
         settle();
         check("hold_stall", bus.id_stall, 1);
         tick();
         check("hold_rd", bus.ex_rd, 9);
         check("hold_pc", bus.ex_pc, 32'h200);
         check("hold_load", bus.ex_load, 0);
      end
      drive(1, 0, 5'd20, 5'd1, 1, 5'd2, 1, 32'h300);
      bus.ex_hold = 1'b0;
      settle();
      check("rel_stall", bus.id_stall, 0);
      tick();
      check("rel_rd", bus.ex_rd, 20);
      check("rel_pc", bus.ex_pc, 32'h300);
      check("rel_valid", bus.ex_valid, 1);

      // reset in the middle of a load-use hazard
      drive(1, 1, 5'd6, 5'd2, 1, 5'd0, 0, 32'h304);
      tick();
      drive(1, 0, 5'd7, 5'd0, 0, 5'd6, 1, 32'h308);
      settle();
      check("rh_stall", bus.id_stall, HZ);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rh_valid", bus.ex_valid, 0);
      check("rh_bcnt", bus.bubble_count, 0);
      check("rh_stall2", bus.id_stall, 0);

`ifdef HAZARD_DETECT_EN
      // preload the counter near the top, then run four load-use pairs
      force dut.r_bubble_count = 16'hFFFD;
      #1;
      release dut.r_bubble_count;
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 5'd6, 5'd2, 1, 5'd0, 0, 32'h400);
         tick();
         drive(1, 0, 5'd7, 5'd6, 1, 5'd0, 0, 32'h404);
         tick();
         if (i == 0)
            check("sat_inc", bus.bubble_count, 16'hFFFE);
         tick();
      end
      check("sat_top", bus.bubble_count, 16'hFFFF);
`else
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 5'd6, 5'd2, 1, 5'd0, 0, 32'h400);
         tick();
         drive(1, 0, 5'd7, 5'd6, 1, 5'd0, 0, 32'h404);
         settle();
         check("nohz_stall", bus.id_stall, 0);
         tick();
      end
      check("nohz_bcnt", bus.bubble_count, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/id_ex_pipeline_register.md
# id_ex_pipeline_register

Decode-to-execute pipeline register of the RV32I 5-stage CPU, sitting directly downstream of the control decoder. It captures the decoded control bundle plus operand data each cycle and presents it to the execute stage. It supports flush (taken branch/jump) and downstream hold, and contains a load-use hazard detector that stalls decode and injects a single bubble into execute.

## Interface
- `XLEN`, 32: datapath width.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `id_write`, `id_store`, `id_load`, `id_branch` input 1 each: control bits from the control decoder.
- `id_alu_operand_a_selector` input 2, `id_alu_operand_b_selector` input 1, `id_immediate_selector` input 2, `id_next_pc_selector` input 2, `id_alu_operations_selector` input 3: selector fields from the control decoder.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_immediate` input XLEN: decode-stage data.
- `id_rd`, `id_rs1`, `id_rs2` input 5: register indices; `id_funct3` input 3.
- `id_rs1_used`, `id_rs2_used` input 1: the decoded instruction reads rs1/rs2.
- `id_valid` input 1: the decode stage holds a real instruction.
- `ex_hold` input 1: the execute stage cannot accept a new instruction; the register freezes.
- `flush` input 1: a redirect is taken in execute; the next captured entry is a bubble.
- `ex_*` output: registered copies of every `id_*` input above except `id_rs1_used`/`id_rs2_used`; `ex_valid` output 1.
- `id_stall` output 1: the decode stage and PC must hold this cycle.
- `bubble_count` output 16: number of load-use bubbles inserted.

## Operation
- Priority at each rising edge: `rst` > `flush` > hazard bubble > `ex_hold` > capture.
- **Reset:** all `ex_*` outputs, `ex_valid` and `bubble_count` become 0. The entry is a bubble.
- **Flush:** `ex_valid` and all control outputs (`ex_write`, `ex_store`, `ex_load`, `ex_branch`, all selectors) become 0. Data/index outputs keep their prior value. Flush overrides `ex_hold` and hazard.
- **Hazard:** `hazard = ex_valid & ex_load & (ex_rd != 0) & id_valid & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd))`.
  - If `hazard` is set, `ex_hold` is 0 and `flush` is 0, a bubble is written (same clearing as flush) and `bubble_count` increments.
  - `bubble_count` saturates at 0xFFFF.
- **Hold:** `ex_hold` set (no flush) keeps all outputs unchanged. No bubble is inserted and `bubble_count` does not change.
- **Capture:** otherwise, every `ex_*` output takes its `id_*` value and `ex_valid <= id_valid`.
- **Stall:** `id_stall = hazard | ex_hold`. It is combinational from the current register state and the `id_*` inputs. `flush` does not suppress `id_stall`; upstream flush logic discards the held decode entry.
- **x0 loads:** a load with `ex_rd == 0` never causes a hazard.
- **Load-use bubbles:** exactly one bubble per load-use pair. In the cycle after the bubble, `ex_load` is 0, so the dependent instruction is captured. The forwarding path supplies the load data.

## Timing
- Latency is 1 cycle from `id_*` to `ex_*`. No combinational path from `id_*` to `ex_*`.
- `id_stall` is valid in the same cycle as the inputs. Its only combinational inputs are `id_valid`, `id_rs1`, `id_rs2`, `id_rs1_used`, `id_rs2_used` and `ex_hold`.
- Load-use sequence:
  - Cycle N: load in EX, dependent instruction in ID; `id_stall=1`.
  - Edge N+1: bubble enters EX.
  - Cycle N+1: `id_stall=0`.
  - Edge N+2: dependent instruction is captured.
- `rst` asserted mid-hold or mid-hazard clears the register on that edge. `id_stall` reads 0 in the following cycle, unless `ex_hold` is asserted.

## Configuration
- `HAZARD_DETECT_EN` defined: load-use detection, bubble injection and `bubble_count` behave as above.
- `HAZARD_DETECT_EN` undefined:
  - `hazard` is constant 0, so `id_stall = ex_hold` only.
  - `bubble_count` is tied to 0.
  - Software must insert a NOP after each load whose result is used by the next instruction.

## Test plan
- Reset, then capture: `rst` for 2 cycles, then ADD (`id_write=1`, `id_rd=5`, `id_valid=1`) -> all outputs are 0 during reset; one edge later `ex_write=1`, `ex_rd=5`, `ex_valid=1`.
- Load-use: LW x6 in EX, then ADD reading x6 in ID -> `id_stall=1` for exactly 1 cycle; EX sees a bubble (`ex_valid=0`, `ex_write=0`), then the ADD; `bubble_count=1`.
- No false hazards: LW x0 followed by an instruction reading x0, and LW x6 followed by LUI x6 (`id_rs1_used=0`) -> `id_stall=0`, no bubble.
- Flush priority: `flush=1` together with a hazard and `ex_hold=1` -> next edge `ex_valid=0`, control outputs 0, `bubble_count` unchanged.
- Hold: `ex_hold=1` for 3 cycles while the `id_*` inputs change -> `ex_*` outputs constant, `id_stall=1` throughout; on release the current `id_*` values are captured.
- Saturation: force 65540 load-use pairs -> `bubble_count` stops at 0xFFFF. Build without `HAZARD_DETECT_EN`: the same load-use stimulus gives `id_stall=0` and `bubble_count=0`.
